fifo_read_pointer_sync_status: RTL
==================================

# fifo_read_pointer_sync_status

Parametrised read-pointer synchroniser and write-side status generator for the async FIFO, clocked in the write domain. Brings the Gray-coded read pointer across through a configurable number of flop stages and decodes it to binary. Computes fill level, full and almost-full against the local binary write pointer. Adds sticky integrity checks for Gray-code violations and impossible fill levels.

## Interface
- DEPTH, 16, FIFO depth; power of two, ≥ 4; AW = $clog2(DEPTH)
- STAGES, 2, synchroniser flop stages; legal 2..4
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when level ≥ this; legal 1..DEPTH
- write_clock  in  1  write-domain clock; all logic on posedge
- write_reset_n  in  1  synchronous, active-low reset
- read_pointer  in  AW+1  Gray-coded read pointer from read domain; asynchronous to write_clock
- write_pointer_bin  in  AW+1  local binary write pointer, write_clock domain
- error_clear  in  1  synchronous clear of the sticky error flags
- sync_read_pointer  out  AW+1  Gray pointer at final synchroniser stage
- sync_read_pointer_bin  out  AW+1  registered binary decode of sync_read_pointer
- write_level  out  AW+1  occupancy seen by writer: (write_pointer_bin − sync_read_pointer_bin) mod 2^(AW+1)
- full  out  1  write_level == DEPTH
- almost_full  out  1  write_level ≥ ALMOST_FULL_LEVEL
- gray_error  out  1  sticky; consecutive synchronised samples differed in more than one bit
- level_error  out  1  sticky; write_level > DEPTH observed

## Operation
- Synchroniser: STAGES-deep shift chain. Stage 1 samples read_pointer. Stage STAGES drives sync_read_pointer. No logic between stages.
- Decoder: bin[AW] = g[AW]; bin[i] = bin[i+1] ^ g[i]. Registered into sync_read_pointer_bin each cycle.
- Previous-sample register holds the prior sync_read_pointer. Each cycle, the bit count of (sync_read_pointer ^ previous) is evaluated:
  - 0 or 1: legal.
  - ≥ 2: set gray_error.
- Status: write_level, full and almost_full are combinational from write_pointer_bin and registered sync_read_pointer_bin. Subtraction is AW+1 bits wide and wraps modulo 2^(AW+1). No glitch-free requirement, since consumers are write-domain flops.
- level_error is set on any cycle with write_level > DEPTH. In that state, full = 0 and almost_full = 1 (pessimistic).
- Sticky flags:
  - error_clear clears gray_error and level_error.
  - A set condition in the same cycle as error_clear wins; the flag stays 1.
- Reset (write_reset_n = 0 at an edge): all synchroniser stages, previous sample, sync_read_pointer_bin, gray_error and level_error go to 0. Reset overrides error_clear and set conditions.
- Reset mid-operation: the pipeline restarts from 0. The first post-reset sample must not raise gray_error; the error check is masked until STAGES+1 edges after reset deassertion.
- Wrap-around: a read pointer crossing 2^(AW+1)−1 → 0 (Gray 1000… → 0000…) is a one-bit change and legal.

## Timing
- read_pointer change → sync_read_pointer: STAGES write_clock edges.
- read_pointer change → sync_read_pointer_bin, write_level, full, almost_full: STAGES+1 edges.
- write_pointer_bin change → write_level/full/almost_full: same cycle (0 latency).
- Violation at stage STAGES → gray_error: visible after 1 edge.
- write_level > DEPTH → level_error: visible after 1 edge.
- Reset values:
  - sync_read_pointer = 0; sync_read_pointer_bin = 0; gray_error = 0; level_error = 0.
  - write_level = write_pointer_bin; full and almost_full follow from write_level.
- Full/empty stance: full is conservative. Reads become visible late, so the writer never overflows; stale reads only delay full deassertion.

## Test plan
- Reset, DEPTH=16, STAGES=2, write_pointer_bin=0 → all outputs 0; gray_error stays 0 for 10 cycles with read_pointer held at 0.
- read_pointer steps 0→1 (Gray 00001) → sync_read_pointer = 1 after 2 edges; sync_read_pointer_bin = 1 after 3 edges. Repeat with STAGES=4 → 4 and 5 edges.
- write_pointer_bin = 16, read_pointer = 0 → write_level = 16, full = 1, almost_full = 1. Read pointer stepped in Gray to bin 1 → full drops exactly 3 edges later; write_level = 15.
- Count both pointers through 31→0 wrap with level held at 5 → write_level stays 5, no flags set.
- read_pointer jumps 00000→00011 → gray_error = 1 after 3 edges and stays set. error_clear pulse → 0. Jump coincident with clear → stays 1.
- write_pointer_bin = 20, rbin = 0 → level_error = 1 next edge, full = 0, almost_full = 1. Reset mid-stream clears it; no spurious gray_error after reset.

Source files
------------

// File: rtl/fifo_read_pointer_sync_status.sv
// Write-domain read-pointer synchroniser with fill level, full/almost-full and sticky integrity flags.
// Latency: read_pointer -> sync_read_pointer STAGES edges, -> status STAGES+1 edges; write_pointer_bin -> status 0.
module fifo_read_pointer_sync_status #(
    parameter int DEPTH             = 16,
    parameter int STAGES            = 2,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
    input  logic                     write_clock,
    input  logic                     write_reset_n,
    input  logic [$clog2(DEPTH):0]   read_pointer,
    input  logic [$clog2(DEPTH):0]   write_pointer_bin,
    input  logic                     error_clear,
    output logic [$clog2(DEPTH):0]   sync_read_pointer,
    output logic [$clog2(DEPTH):0]   sync_read_pointer_bin,
    output logic [$clog2(DEPTH):0]   write_level,
    output logic                     full,
    output logic                     almost_full,
    output logic                     gray_error,
    output logic                     level_error
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AF_L    = (AW + 1)'(ALMOST_FULL_LEVEL);
    localparam int            CW      = $clog2(STAGES + 2);
    localparam logic [CW-1:0] ARMED   = CW'(STAGES + 1);

    logic [AW:0]   stage_q [STAGES];
    logic [AW:0]   stage_d [STAGES];
    logic [AW:0]   prev_q, prev_d;
    logic [AW:0]   bin_q, bin_d;
    logic [CW-1:0] arm_q, arm_d;
    logic          gray_err_q, gray_err_d;
    logic          level_err_q, level_err_d;

    logic [AW:0]   sync_g;
    logic [AW:0]   dec;
    logic [AW:0]   level;
    logic          gray_viol;
    logic          level_viol;

    always_comb begin
        stage_d[0] = read_pointer;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        sync_g = stage_q[STAGES-1];

        dec     = '0;
        dec[AW] = sync_g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            dec[i] = dec[i+1] ^ sync_g[i];
        end

        prev_d = sync_g;
        bin_d  = dec;

        // The first compares after reset pit real samples against reset zeros; hold off until both are genuine.
        arm_d     = (arm_q == ARMED) ? arm_q : arm_q + CW'(1);
        gray_viol = (arm_q == ARMED) && ($countones(sync_g ^ prev_q) > 1);

        level      = write_pointer_bin - bin_q;
        level_viol = level > DEPTH_L;

        gray_err_d  = gray_viol  | (gray_err_q  & ~error_clear);
        level_err_d = level_viol | (level_err_q & ~error_clear);
    end

    always_ff @(posedge write_clock) begin
        if (!write_reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q      <= '0;
            bin_q       <= '0;
            arm_q       <= '0;
            gray_err_q  <= 1'b0;
            level_err_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            prev_q      <= prev_d;
            bin_q       <= bin_d;
            arm_q       <= arm_d;
            gray_err_q  <= gray_err_d;
            level_err_q <= level_err_d;
        end
    end

    // An impossible level reports not-full but almost-full so the writer stalls rather than overflows.
    assign sync_read_pointer     = sync_g;
    assign sync_read_pointer_bin = bin_q;
    assign write_level           = level;
    assign full                  = !level_viol && (level == DEPTH_L);
    assign almost_full           = level_viol || (level >= AF_L);
    assign gray_error            = gray_err_q;
    assign level_error           = level_err_q;
endmodule
